keypad_scan_ctrl: RTL and testbench

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

---
 rtl/keypad_scan_ctrl.sv | 148 ++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner with settle/debounce, press/release tracking and a
// valid/ack handshake. Two-phase clocked: ph2 master captures, ph1 slave launches.
module keypad_scan_ctrl #(
  parameter int SETTLE_CYC   = 2,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic       ph1,
  input  logic       ph2,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] rows,
  input  logic       key_ack,
  output logic [3:0] columns,
  output logic [3:0] key_code,
  output logic       key_valid
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRIVE    = 3'd1,
    DEBOUNCE = 3'd2,
    HELD     = 3'd3,
    RELEASE  = 3'd4,
    WAIT_ACK = 3'd5
  } state_e;

  typedef struct packed {
    state_e     st;
    logic [1:0] col;
    logic [1:0] row;
    logic [3:0] settle;
    logic [3:0] match;
    logic [3:0] rel;
    logic [3:0] code;
    logic       valid;
    logic [3:0] cols;
  } regs_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [3:0] DEB_LAST    = 4'(DEBOUNCE_CNT - 1);

  regs_t      d, m, q;
  logic       one_row;
  logic [1:0] row_enc;
  logic [3:0] row_mask;

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

  always_comb begin
    one_row  = (rows != 4'b0) && ((rows & (rows - 4'd1)) == 4'b0);
    row_enc  = 2'd0;
    for (int i = 0; i < 4; i++)
      if (rows[i]) row_enc = 2'(i);
    row_mask = 4'b1 << q.row;

    d       = q;
    d.valid = q.valid & ~key_ack;
    if (!en) begin
      // key_valid/key_code survive a disable; only the scan context is dropped
      d.st     = IDLE;
      d.col    = '0;
      d.row    = '0;
      d.settle = '0;
      d.match  = '0;
      d.rel    = '0;
    end else begin
      unique case (q.st)
        IDLE: begin
          d.st     = DRIVE;
          d.col    = '0;
          d.settle = '0;
        end
        DRIVE: begin
          if (q.settle == SETTLE_LAST) begin
            d.settle = '0;
            if (one_row) begin
              d.st    = DEBOUNCE;
              d.row   = row_enc;
              d.match = 4'd1;
            end else begin
              d.col = q.col + 2'd1;
            end
          end else begin
            d.settle = sat_inc(q.settle);
          end
        end
        DEBOUNCE: begin
          if (rows == row_mask) begin
            d.match = sat_inc(q.match);
            if (q.match == DEB_LAST) begin
              // an unacked key blocks acceptance unless it is acked this cycle
              if (!q.valid || key_ack) begin
                d.st    = HELD;
                d.code  = {q.row, q.col};
                d.valid = 1'b1;
              end else begin
                d.st = WAIT_ACK;
              end
            end
          end else begin
            d.st     = DRIVE;
            d.settle = '0;
          end
        end
        HELD: begin
          if (!rows[q.row]) begin
            d.st  = RELEASE;
            d.rel = 4'd1;
          end
        end
        RELEASE: begin
          if (!rows[q.row]) begin
            d.rel = sat_inc(q.rel);
            if (q.rel == DEB_LAST) begin
              d.st     = DRIVE;
              d.col    = q.col + 2'd1;
              d.settle = '0;
            end
          end else begin
            d.st = HELD;
          end
        end
        WAIT_ACK: begin
          if (!q.valid) begin
            d.st     = DRIVE;
            d.settle = '0;
          end
        end
        default: d.st = IDLE;
      endcase
    end
    d.cols = (d.st inside {DRIVE, DEBOUNCE, HELD, RELEASE}) ? (4'b1 << d.col) : 4'b0;
  end

  always_ff @(negedge ph2) begin
    if (!reset) m <= '0;
    else        m <= d;
  end

  always_ff @(posedge ph1) q <= m;

  assign columns   = q.cols;
  assign key_code  = q.code;
  assign key_valid = q.valid;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: directed scenarios plus randomized key activity,
// every cycle compared against a behavioural keypad-scanner model.
module tb_keypad_scan_ctrl;
  localparam int SETTLE = 2;
  localparam int DEB    = 3;

  logic       ph1, ph2, reset, en, key_ack;
  logic [3:0] rows, columns, key_code;
  logic       key_valid;

  keypad_scan_ctrl #(.SETTLE_CYC(SETTLE), .DEBOUNCE_CNT(DEB)) dut (
    .ph1(ph1), .ph2(ph2), .reset(reset), .en(en), .rows(rows),
    .key_ack(key_ack), .columns(columns), .key_code(key_code), .key_valid(key_valid)
  );

  initial begin
    ph1 = 0; ph2 = 0;
    forever begin
      #1 ph1 = 1; #3 ph1 = 0; #1 ph2 = 1; #3 ph2 = 0; #2;
    end
  end

  int n_checks = 0, n_err = 0;
  bit chk_on = 0;

  // staged inputs for the next cycle; s_keys bit r*4+c = key (row r, col c) down
  bit          s_rst, s_en, s_ack, s_noise;
  logic [15:0] s_keys;
  logic [3:0]  s_noise_val;

  // model: 0 idle, 1 scanning, 2 confirming, 3 held, 4 releasing, 5 waiting for ack
  int         md_mode, md_col, md_row, md_n;
  bit         md_valid;
  logic [3:0] md_code;

  function automatic logic [3:0] md_cols();
    return (md_mode >= 1 && md_mode <= 4) ? 4'(1 << md_col) : 4'b0;
  endfunction

  task automatic model_step(input bit rst_n, input bit e, input logic [3:0] r, input bit ack);
    bit nv;
    if (!rst_n) begin
      md_mode = 0; md_col = 0; md_row = 0; md_n = 0; md_valid = 0; md_code = 0;
      return;
    end
    nv = md_valid && !ack;
    if (!e) begin
      md_mode = 0; md_col = 0; md_n = 0; md_valid = nv;
      return;
    end
    case (md_mode)
      0: begin md_mode = 1; md_col = 0; md_n = 0; end
      1: begin
        md_n++;
        if (md_n == SETTLE) begin
          md_n = 0;
          if ($countones(r) == 1) begin md_row = $clog2(r); md_mode = 2; md_n = 1; end
          else md_col = (md_col + 1) % 4;
        end
      end
      2: begin
        if (r == 4'(1 << md_row)) begin
          md_n++;
          if (md_n == DEB) begin
            if (!md_valid || ack) begin
              md_code = 4'(md_row * 4 + md_col); nv = 1; md_mode = 3;
            end else md_mode = 5;
          end
        end else begin md_mode = 1; md_n = 0; end
      end
      3: if (!r[md_row]) begin md_mode = 4; md_n = 1; end
      4: begin
        if (!r[md_row]) begin
          md_n++;
          if (md_n == DEB) begin md_col = (md_col + 1) % 4; md_mode = 1; md_n = 0; end
        end else md_mode = 3;
      end
      5: if (!md_valid) begin md_mode = 1; md_n = 0; end
      default: md_mode = 0;
    endcase
    md_valid = nv;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // one clock cycle: compare outputs, then present staged inputs and advance model
  task automatic tick();
    logic [3:0] ec, r;
    @(posedge ph1); #1;
    ec = md_cols();
    if (chk_on) begin
      chk("columns", columns, ec);
      chk("key_valid", {3'b0, key_valid}, {3'b0, md_valid});
      chk("key_code", key_code, md_code);
    end
    r = 4'b0;
    for (int k = 0; k < 16; k++)
      if (s_keys[k] && ec[k % 4]) r[k / 4] = 1'b1;
    if (s_noise) r = s_noise_val;
    reset = s_rst; en = s_en; key_ack = s_ack; rows = r;
    model_step(s_rst, s_en, r, s_ack);
  endtask

  // after start() the next tick() is the first DRIVE cycle (cycle 0)
  task automatic start();
    s_rst = 0; s_en = 0; s_ack = 0; s_keys = 0; s_noise = 0;
    tick(); chk_on = 1; tick();
    s_rst = 1; s_en = 1;
    tick();
  endtask

  logic [3:0] seq_tbl [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                              4'b0100, 4'b1000, 4'b1000, 4'b0001};
  bit found;

  initial begin
    reset = 0; en = 0; key_ack = 0; rows = 0;
    md_mode = 0; md_col = 0; md_row = 0; md_n = 0; md_valid = 0; md_code = 0;

    // reset state and idle scan sequence
    start();
    chk("rst_columns", columns, 4'b0000);
    chk("rst_valid", {3'b0, key_valid}, 4'b0);
    chk("rst_code", key_code, 4'b0000);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("scan_seq", columns, seq_tbl[i]);
    end
    chk("scan_novalid", {3'b0, key_valid}, 4'b0);

    // clean press at row2/col1, then disable while held
    start();
    s_keys = 16'(1 << 9);
    for (int i = 0; i < 6; i++) tick();
    chk("press_c5_valid", {3'b0, key_valid}, 4'b0);
    tick();
    chk("press_c6_valid", {3'b0, key_valid}, 4'b1);
    chk("press_c6_code", key_code, 4'b1001);
    chk("press_c6_cols", columns, 4'b0010);
    s_en = 0; tick(); tick();
    chk("en_drop_cols", columns, 4'b0000);
    chk("en_drop_valid", {3'b0, key_valid}, 4'b1);
    chk("en_drop_code", key_code, 4'b1001);
    s_en = 1; s_keys = 0; tick(); tick();
    s_ack = 1; tick(); s_ack = 0; tick();

    // reset while held discards the key
    start();
    s_keys = 16'(1 << 9);
    for (int i = 0; i < 7; i++) tick();
    s_rst = 0; tick(); tick();
    chk("rst_held_cols", columns, 4'b0000);
    chk("rst_held_valid", {3'b0, key_valid}, 4'b0);
    chk("rst_held_code", key_code, 4'b0000);
    s_rst = 1; s_keys = 0;

    // bounce: two good samples then a dropout
    start();
    s_keys = 16'(1 << 4);
    tick(); tick(); tick();
    s_keys = 0;
    tick(); tick();
    chk("bounce_c4", columns, 4'b0001);
    tick();
    chk("bounce_c5", columns, 4'b0001);
    tick();
    chk("bounce_c6", columns, 4'b0010);
    chk("bounce_valid", {3'b0, key_valid}, 4'b0);

    // two rows on one column
    start();
    s_keys = 16'((1 << 0) | (1 << 4));
    tick(); tick(); tick();
    chk("multi_cols", columns, 4'b0010);
    chk("multi_valid", {3'b0, key_valid}, 4'b0);
    s_keys = 0;

    // second key while first unacked
    start();
    s_keys = 16'(1 << 4);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin tick(); found = key_valid; end
    chk("k1_found", {3'b0, found}, 4'b1);
    chk("k1_code", key_code, 4'b0100);
    s_keys = 16'(1 << 14);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin tick(); found = (columns == 4'b0) && key_valid; end
    chk("wait_found", {3'b0, found}, 4'b1);
    chk("wait_code", key_code, 4'b0100);
    s_ack = 1; tick(); s_ack = 0; tick();
    chk("ack_clears", {3'b0, key_valid}, 4'b0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin tick(); found = key_valid; end
    chk("k2_found", {3'b0, found}, 4'b1);
    chk("k2_code", key_code, 4'b1110);
    s_keys = 0;

    // randomized activity
    start();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19) == 0) begin
        case ($urandom_range(9))
          0, 1, 2, 3, 4: s_keys = 0;
          8, 9:          s_keys = 16'(1 << $urandom_range(15)) | 16'(1 << $urandom_range(15));
          default:       s_keys = 16'(1 << $urandom_range(15));
        endcase
      end
      s_ack       = ($urandom_range(5) == 0);
      s_en        = ($urandom_range(79) != 0);
      s_rst       = ($urandom_range(299) != 0);
      s_noise     = ($urandom_range(24) == 0);
      s_noise_val = 4'($urandom_range(15));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
